gamepad_reader: RTL and testbench
=================================

# gamepad_reader

Host-side initiator for the SNES-style serial gamepad interface: drives `pad_latch` and `pad_clk`, and shifts in both players' button states from the 2-bit `pad_data` bus. Its responder is either a real gamepad PMOD or `mock_gamepad` on boards with discrete buttons. It sits in the `clk_2x` domain inside `ics32` and presents parallel, atomically-updated button words to the CPU-visible peripheral registers. Polls run on request; the caller decides the polling rate, typically one poll per vblank.

## Interface

Parameters:
- `HALF_PERIOD`, default 48: `pad_clk` half-period in `clk` cycles. Must be ≥ 1.
- `BUTTON_COUNT`, default 12: bits shifted per poll. Must be 1..16.

Ports:
- `clk`  in  1  system clock (`clk_2x`).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  poll request. Sampled each cycle; accepted only when `busy`=0.
- `busy`  out  1  high from the cycle after acceptance until the `valid` cycle, exclusive.
- `valid`  out  1  one-cycle pulse; `p1_buttons` and `p2_buttons` are updated in this cycle.
- `pad_latch`  out  1  latch strobe to the pad, active-high.
- `pad_clk`  out  1  shift clock to the pad; idles high.
- `pad_data`  in  2  serial data. Bit 0 is P1, bit 1 is P2. Active-high (1 = pressed); inversion and input flops are done upstream.
- `p1_buttons`  out  BUTTON_COUNT  last completed P1 sample. Bit i is the i-th shifted bit.
- `p2_buttons`  out  BUTTON_COUNT  last completed P2 sample.

## Operation

- **FSM states:** IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE. All outputs are registered.
- **IDLE:** `pad_latch`=0, `pad_clk`=1, `busy`=0. When `start`=1, go to LATCH.
- **LATCH:** `pad_latch`=1 for 2·HALF_PERIOD cycles. Clear the bit index. Go to CLK_LOW.
- **CLK_LOW:** `pad_clk`=0 for HALF_PERIOD cycles. On the last cycle, shift `pad_data[0]` and `pad_data[1]` into bit[index] of the P1 and P2 shadow registers. Go to CLK_HIGH.
- **CLK_HIGH:** `pad_clk`=1 for HALF_PERIOD cycles; the responder advances on this rising edge. On the last cycle:
  - if index = BUTTON_COUNT−1, go to DONE;
  - otherwise increment index and go to CLK_LOW.
- **DONE:** lasts one cycle.
  - Copy the shadow registers to `p1_buttons` and `p2_buttons`.
  - `valid`=1, `busy`=0.
  - Return to IDLE.
  - A `start` in this cycle is accepted as if in IDLE, so back-to-back polls are possible.
- **Counters:** the phase counter is a ⌈log2(2·HALF_PERIOD)⌉-bit down-counter, reloaded on every state entry. The index is ⌈log2(BUTTON_COUNT)⌉ bits wide, with no wrap beyond BUTTON_COUNT−1.
- **Output stability:** `p1_buttons` and `p2_buttons` change only in the `valid` cycle. Partial results are never visible.
- **`start` while busy:** ignored. It is not queued and has no effect on the current poll.
- **`pad_data` outside sample points:** ignored.

## Timing

- Count the cycle in which `start` is accepted as cycle 0.
- `pad_latch`=1 in cycles 1..2H, where H = HALF_PERIOD.
- For bit i:
  - `pad_clk`=0 in cycles 2H+1+2Hi .. 3H+2Hi;
  - sample taken in cycle 3H+2Hi;
  - `pad_clk`=1 in cycles 3H+1+2Hi .. 2H+2H(i+1).
- `valid` is asserted in cycle 2H(BUTTON_COUNT+1)+1. With the defaults this is cycle 1249.
- `busy`=1 in cycles 1 .. 2H(BUTTON_COUNT+1).
- `pad_latch` and `pad_clk` are never both low-going in the same cycle. `pad_clk` stays high throughout the latch pulse.
- **Reset values (next edge with `reset`=1):**
  - state IDLE;
  - `pad_latch`=0, `pad_clk`=1;
  - `busy`=0, `valid`=0;
  - `p1_buttons`=0, `p2_buttons`=0;
  - shadow registers and counters zeroed.
- **Reset mid-poll:** the poll is aborted. No `valid` is produced, and the outputs take their reset values on the next edge.

## Test plan

- **Reset:** assert `reset` for 2 cycles with `start`=1 → `pad_latch`=0, `pad_clk`=1, `busy`=0, `valid`=0, both button words 0; no latch pulse while `reset` is held.
- **Default poll:** defaults, responder model loaded with P1=12'hA5C and P2=12'h3F0, pulse `start` → latch high for 96 cycles; 12 low pulses of 48 cycles; `valid` at cycle 1249 with `p1_buttons`=12'hA5C, `p2_buttons`=12'h3F0; words unchanged before that cycle.
- **`start` while busy:** hold `start`=1 continuously for cycles 0..600 → exactly one latch pulse and one `valid`, at cycle 1249.
- **Back-to-back:** assert `start` in the `valid` cycle with a new pattern, P1=12'hFFF and P2=12'h001 → second latch pulse starts the next cycle; second `valid` 1249 cycles after the first with the new values.
- **Reset mid-poll:** `reset` at cycle 500 → next cycle `pad_clk`=1, `pad_latch`=0, `busy`=0, button words 0; `valid` never asserts for that poll.
- **Minimum parameters:** HALF_PERIOD=1, BUTTON_COUNT=1, `pad_data`=2'b10 → latch in cycles 1–2, `pad_clk` low in cycle 3, `valid` in cycle 5 with `p1_buttons`=0 and `p2_buttons`=1.

Source files
------------

// File: rtl/gamepad_reader.sv
// gamepad_reader: SNES-style serial pad poller. It drives latch and clock, shifts in
// both players' buttons, then publishes both words together with a one-cycle valid.
module gamepad_reader #(
    parameter int HALF_PERIOD  = 48,
    parameter int BUTTON_COUNT = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    valid,
    output logic                    pad_latch,
    output logic                    pad_clk,
    input  logic [1:0]              pad_data,
    output logic [BUTTON_COUNT-1:0] p1_buttons,
    output logic [BUTTON_COUNT-1:0] p2_buttons
);

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam int IW = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;
    localparam logic [CW-1:0] LATCH_LOAD = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(BUTTON_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BUTTON_COUNT-1:0] sh1_q, sh1_d;
    logic [BUTTON_COUNT-1:0] sh2_q, sh2_d;
    logic [BUTTON_COUNT-1:0] p1_q, p1_d;
    logic [BUTTON_COUNT-1:0] p2_q, p2_d;
    logic                    latch_q, latch_d;
    logic                    pad_clk_q, pad_clk_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        p1_d    = p1_q;
        p2_d    = p2_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE so polls can run back to back
                if (start) begin
                    state_d = LATCH;
                    cnt_d   = LATCH_LOAD;
                    idx_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = CLK_LOW;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CLK_LOW: begin
                if (cnt_q == '0) begin
                    for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
                        if (idx_q == IW'(i)) begin
                            sh1_d[i] = pad_data[0];
                            sh2_d[i] = pad_data[1];
                        end
                    end
                    state_d = CLK_HIGH;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CLK_HIGH: begin
                if (cnt_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        p1_d    = sh1_q;
                        p2_d    = sh2_q;
                    end else begin
                        state_d = CLK_LOW;
                        cnt_d   = HALF_LOAD;
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered copies decoded from the next state
        latch_d   = (state_d == LATCH);
        pad_clk_d = (state_d != CLK_LOW);
        busy_d    = (state_d == LATCH) || (state_d == CLK_LOW) || (state_d == CLK_HIGH);
        valid_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            latch_q   <= 1'b0;
            pad_clk_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            latch_q   <= latch_d;
            pad_clk_q <= pad_clk_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign valid      = valid_q;
    assign pad_latch  = latch_q;
    assign pad_clk    = pad_clk_q;
    assign p1_buttons = p1_q;
    assign p2_buttons = p2_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader: default-parameter instance with a pad responder
// model, plus a minimum-parameter instance driven with constant data.
module tb_gamepad_reader;

    localparam int H    = 48;
    localparam int BC   = 12;
    localparam int LAST = 2 * H * (BC + 1);
    localparam int VC   = LAST + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, start_m;
    logic          busy, valid, pad_latch, pad_clk;
    logic [1:0]    pad_data;
    logic [BC-1:0] p1_buttons, p2_buttons;
    logic          busy_m, valid_m, pad_latch_m, pad_clk_m;
    logic [1:0]    pad_data_m;
    logic [0:0]    p1_m, p2_m;

    int checks   = 0;
    int failures = 0;

    gamepad_reader #(.HALF_PERIOD(H), .BUTTON_COUNT(BC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .valid(valid),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data),
        .p1_buttons(p1_buttons), .p2_buttons(p2_buttons)
    );

    gamepad_reader #(.HALF_PERIOD(1), .BUTTON_COUNT(1)) dut_min (
        .clk(clk), .reset(reset), .start(start_m), .busy(busy_m), .valid(valid_m),
        .pad_latch(pad_latch_m), .pad_clk(pad_clk_m), .pad_data(pad_data_m),
        .p1_buttons(p1_m), .p2_buttons(p2_m)
    );

    assign pad_data_m = 2'b10;

    // Responder: shifts on each pad_clk rise; data is only valid in the last low cycle
    logic [BC-1:0] pat1 = '0, pat2 = '0;
    int            ptr  = 0;
    int            lowc = 0;
    logic          prev_pc = 1'b1;
    logic [1:0]    cur;

    always @(posedge clk) begin
        prev_pc <= pad_clk;
        if (pad_latch === 1'b1) ptr <= 0;
        else if (pad_clk === 1'b1 && prev_pc === 1'b0) ptr <= ptr + 1;
        if (pad_clk === 1'b0) lowc <= lowc + 1;
        else lowc <= 0;
    end

    always_comb begin
        cur = 2'b00;
        if (ptr < BC) cur = {pat2[ptr[3:0]], pat1[ptr[3:0]]};
        if (pad_clk === 1'b0 && lowc == H - 1) pad_data = cur;
        else pad_data = ~cur;
    end

    // Runs one poll from the current negedge (cycle 0) and measures it against the ideal waveform
    task automatic observe(input int ncyc, input int hold,
                           input logic [BC-1:0] old1, input logic [BC-1:0] old2,
                           output int lat_n, output int low_n, output int val_n,
                           output int val_cyc, output int wave_err, output int first_bad,
                           output int early_chg);
        logic prev_s;
        logic e_lat, e_low, e_busy, e_val;
        lat_n = 0; low_n = 0; val_n = 0; val_cyc = -1;
        wave_err = 0; first_bad = -1; early_chg = 0;
        prev_s = pad_clk;
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c <= hold);
            e_lat  = (c >= 1) && (c <= 2 * H);
            e_low  = (c > 2 * H) && (c <= LAST) && (((c - 2 * H - 1) % (2 * H)) < H);
            e_busy = (c >= 1) && (c <= LAST);
            e_val  = (c == VC);
            if (pad_latch !== e_lat || pad_clk !== !e_low || busy !== e_busy || valid !== e_val) begin
                wave_err++;
                if (first_bad < 0) first_bad = c;
            end
            if (pad_latch === 1'b1) lat_n++;
            if (prev_s === 1'b1 && pad_clk === 1'b0) low_n++;
            prev_s = pad_clk;
            if (valid === 1'b1) begin
                val_n++;
                val_cyc = c;
            end
            if (val_n == 0 && (p1_buttons !== old1 || p2_buttons !== old2)) early_chg++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start_m = 1'b1;
        @(negedge clk);
        checks++;
        if (pad_latch !== 1'b0 || pad_latch_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_latch_c1 got=%b/%b exp=0/0", pad_latch, pad_latch_m);
        end
        @(negedge clk);
        checks++;
        if ({pad_latch, pad_clk, busy, valid} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctrl got latch,clk,busy,valid=%b exp=0100", {pad_latch, pad_clk, busy, valid});
        end
        checks++;
        if (p1_buttons !== '0 || p2_buttons !== '0) begin
            failures++;
            $display("FAIL reset_words got=%h/%h exp=000/000", p1_buttons, p2_buttons);
        end
        checks++;
        if ({pad_latch_m, pad_clk_m, busy_m, valid_m, p1_m, p2_m} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_min got=%b exp=010000", {pad_latch_m, pad_clk_m, busy_m, valid_m, p1_m, p2_m});
        end
        reset = 1'b0; start = 1'b0; start_m = 1'b0;
        @(negedge clk);
        checks++;
        if (pad_latch !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got latch=%b busy=%b exp=0 0", pad_latch, busy);
        end
    endtask

    task automatic test_default_poll();
        int lat_n, low_n, val_n, val_cyc, werr, fbad, early;
        pat1 = 12'hA5C; pat2 = 12'h3F0;
        observe(VC + 20, 0, 12'h000, 12'h000, lat_n, low_n, val_n, val_cyc, werr, fbad, early);
        checks++;
        if (lat_n !== 2 * H) begin failures++; $display("FAIL default_latch_len got=%0d exp=%0d", lat_n, 2 * H); end
        checks++;
        if (low_n !== BC) begin failures++; $display("FAIL default_low_pulses got=%0d exp=%0d", low_n, BC); end
        checks++;
        if (val_n !== 1 || val_cyc !== VC) begin
            failures++; $display("FAIL default_valid got count=%0d cycle=%0d exp 1 at %0d", val_n, val_cyc, VC);
        end
        checks++;
        if (werr !== 0) begin failures++; $display("FAIL default_waveform got=%0d bad cycles (first %0d) exp=0", werr, fbad); end
        checks++;
        if (early !== 0) begin failures++; $display("FAIL default_early_update got=%0d exp=0", early); end
        checks++;
        if (p1_buttons !== 12'hA5C) begin failures++; $display("FAIL default_p1 got=%h exp=a5c", p1_buttons); end
        checks++;
        if (p2_buttons !== 12'h3F0) begin failures++; $display("FAIL default_p2 got=%h exp=3f0", p2_buttons); end
    endtask

    task automatic test_start_while_busy();
        int lat_n, low_n, val_n, val_cyc, werr, fbad, early;
        pat1 = 12'h123; pat2 = 12'hEDC;
        observe(VC + 100, 600, 12'hA5C, 12'h3F0, lat_n, low_n, val_n, val_cyc, werr, fbad, early);
        checks++;
        if (lat_n !== 2 * H) begin failures++; $display("FAIL busy_latch_len got=%0d exp=%0d", lat_n, 2 * H); end
        checks++;
        if (val_n !== 1 || val_cyc !== VC) begin
            failures++; $display("FAIL busy_valid got count=%0d cycle=%0d exp 1 at %0d", val_n, val_cyc, VC);
        end
        checks++;
        if (werr !== 0) begin failures++; $display("FAIL busy_waveform got=%0d bad cycles (first %0d) exp=0", werr, fbad); end
        checks++;
        if (early !== 0) begin failures++; $display("FAIL busy_early_update got=%0d exp=0", early); end
        checks++;
        if (p1_buttons !== 12'h123 || p2_buttons !== 12'hEDC) begin
            failures++; $display("FAIL busy_words got=%h/%h exp=123/edc", p1_buttons, p2_buttons);
        end
    endtask

    task automatic test_back_to_back();
        int lat_n, low_n, val_n, val_cyc, werr, fbad, early;
        pat1 = 12'h5A5; pat2 = 12'h0F0;
        observe(VC, 0, 12'h123, 12'hEDC, lat_n, low_n, val_n, val_cyc, werr, fbad, early);
        checks++;
        if (val_cyc !== VC || valid !== 1'b1 || p1_buttons !== 12'h5A5 || p2_buttons !== 12'h0F0) begin
            failures++;
            $display("FAIL b2b_first got valid_cycle=%0d words=%h/%h exp %0d 5a5/0f0", val_cyc, p1_buttons, p2_buttons, VC);
        end
        pat1 = 12'hFFF; pat2 = 12'h001;
        observe(VC + 10, 0, 12'h5A5, 12'h0F0, lat_n, low_n, val_n, val_cyc, werr, fbad, early);
        checks++;
        if (werr !== 0) begin failures++; $display("FAIL b2b_waveform got=%0d bad cycles (first %0d) exp=0", werr, fbad); end
        checks++;
        if (val_n !== 1 || val_cyc !== VC) begin
            failures++; $display("FAIL b2b_valid got count=%0d cycle=%0d exp 1 at %0d", val_n, val_cyc, VC);
        end
        checks++;
        if (early !== 0) begin failures++; $display("FAIL b2b_early_update got=%0d exp=0", early); end
        checks++;
        if (p1_buttons !== 12'hFFF || p2_buttons !== 12'h001) begin
            failures++; $display("FAIL b2b_words got=%h/%h exp=fff/001", p1_buttons, p2_buttons);
        end
    endtask

    task automatic test_reset_mid_poll();
        int val_n, lat_n;
        pat1 = 12'h0AA; pat2 = 12'h055;
        start = 1'b1;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (pad_clk !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL midreset_pre got clk=%b busy=%b exp=0 1", pad_clk, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({pad_latch, pad_clk, busy, valid} !== 4'b0100) begin
            failures++; $display("FAIL midreset_ctrl got latch,clk,busy,valid=%b exp=0100", {pad_latch, pad_clk, busy, valid});
        end
        checks++;
        if (p1_buttons !== '0 || p2_buttons !== '0) begin
            failures++; $display("FAIL midreset_words got=%h/%h exp=000/000", p1_buttons, p2_buttons);
        end
        val_n = 0; lat_n = 0;
        for (int c = 0; c < VC + 50; c++) begin
            @(negedge clk);
            if (valid === 1'b1) val_n++;
            if (pad_latch === 1'b1) lat_n++;
        end
        checks++;
        if (val_n !== 0 || lat_n !== 0) begin
            failures++; $display("FAIL midreset_aftermath got valid=%0d latch=%0d exp=0 0", val_n, lat_n);
        end
    endtask

    task automatic test_min_params();
        int werr, fbad, val_n;
        logic e_lat, e_low, e_busy, e_val;
        werr = 0; fbad = -1; val_n = 0;
        start_m = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_m = 1'b0;
            e_lat  = (c == 1) || (c == 2);
            e_low  = (c == 3);
            e_busy = (c >= 1) && (c <= 4);
            e_val  = (c == 5);
            if (pad_latch_m !== e_lat || pad_clk_m !== !e_low || busy_m !== e_busy || valid_m !== e_val) begin
                werr++;
                if (fbad < 0) fbad = c;
            end
            if (valid_m === 1'b1) val_n++;
            if (c == 5) begin
                checks++;
                if (p1_m !== 1'b0 || p2_m !== 1'b1) begin
                    failures++; $display("FAIL min_words got=%b/%b exp=0/1", p1_m, p2_m);
                end
            end
        end
        checks++;
        if (werr !== 0) begin failures++; $display("FAIL min_waveform got=%0d bad cycles (first %0d) exp=0", werr, fbad); end
        checks++;
        if (val_n !== 1) begin failures++; $display("FAIL min_valid_count got=%0d exp=1", val_n); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start_m = 1'b0;
        test_reset();
        test_default_poll();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_poll();
        test_min_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
